// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// the totals and sync windows derived from it, and bus widths.
package vga_timing_pkg;

    localparam int COLOR_W = 4;
    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // Drive pol while the sync window is active, the opposite level otherwise.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Board-clock divider: one-clock pix_tick every CLK_DIV clocks, held at
// count 0 while en is low so a restart always begins a full pixel period.
module pixel_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic board_clk,
    input  logic Reset_n,
    input  logic en,
    output logic pix_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        div_d = '0;
        if (en && div_q != DIV_MAX) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge board_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters plus a registered sync and colour
// stage that lags the published coordinate by exactly one pixel period.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic                   board_clk,
    input  logic                   Reset_n,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic [COORD_W-1:0]     pixel_x,
    output logic [COORD_W-1:0]     pixel_y,
    output logic                   video_on,
    output logic                   pix_tick,
    output logic                   frame_tick,
    output logic                   hSync,
    output logic                   vSync,
    output logic [COLOR_W-1:0]     vgaR,
    output logic [COLOR_W-1:0]     vgaG,
    output logic [COLOR_W-1:0]     vgaB
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_VIS_LAST = COORD_W'(H_VISIBLE - 1);
    localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_VISIBLE - 1);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
    // One extra bit: a window ending exactly at 1024 must still compare correctly.
    localparam logic [COORD_W:0]   HS_END   = (COORD_W+1)'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [COORD_W:0]   VS_END   = (COORD_W+1)'(V_VISIBLE + V_FP + V_SYNC);

    logic [COORD_W-1:0]   hcount_q, hcount_d;
    logic [COORD_W-1:0]   vcount_q, vcount_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 tick;
    logic                 line_end;
    logic                 h_in_sync;
    logic                 v_in_sync;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .board_clk (board_clk),
        .Reset_n   (Reset_n),
        .en        (en),
        .pix_tick  (tick)
    );

    assign line_end  = (hcount_q == H_LAST);
    assign video_on  = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign h_in_sync = (hcount_q >= HS_START) && ({1'b0, hcount_q} < HS_END);
    assign v_in_sync = (vcount_q >= VS_START) && ({1'b0, vcount_q} < VS_END);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        rgb_d    = rgb_q;
        if (!en) begin
            hcount_d = '0;
            vcount_d = '0;
            hsync_d  = ~SYNC_POL;
            vsync_d  = ~SYNC_POL;
            rgb_d    = '0;
        end else if (tick) begin
            hcount_d = line_end ? '0 : hcount_q + COORD_W'(1);
            if (line_end) begin
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + COORD_W'(1);
            end
            // Output stage samples the pixel that is ending, keeping sync and colour aligned.
            hsync_d = sync_level(h_in_sync, SYNC_POL);
            vsync_d = sync_level(v_in_sync, SYNC_POL);
            rgb_d   = video_on ? rgb_in : '0;
        end
    end

    always_ff @(posedge board_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pixel_x    = hcount_q;
    assign pixel_y    = vcount_q;
    assign pix_tick   = tick;
    assign frame_tick = tick && (hcount_q == H_VIS_LAST) && (vcount_q == V_VIS_LAST);
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign {vgaR, vgaG, vgaB} = rgb_q;

endmodule
